// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word with range/alignment checks.
// Registered output stage plus one skid entry keeps in_ready free of any path from out_ready.
module inst_encoder #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           fmt,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHIFT = 3'd6,
    FMT_ILL   = 3'd7
  } fmt_e;

  fmt_e                 w_fmt;
  logic [31:0]          w_instr;
  logic                 w_err;
  logic                 w_acc;
  logic                 w_out_free;
  logic                 w_hi11_ok;
  logic                 w_hi12_ok;
  logic                 w_hi20_ok;

  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [31:0]          r_out_instr;
  logic                 r_out_err;
  logic                 r_sk_valid;
  logic [31:0]          r_sk_instr;
  logic                 r_sk_err;
  logic [ERR_CNT_W-1:0] r_err_count;

  assign w_fmt      = fmt_e'(fmt);
  // A value fits in N signed bits when all bits above N-1 match the sign bit.
  assign w_hi11_ok  = (&imm[31:11]) || (~|imm[31:11]);
  assign w_hi12_ok  = (&imm[31:12]) || (~|imm[31:12]);
  assign w_hi20_ok  = (&imm[31:20]) || (~|imm[31:20]);

  always_comb begin
    w_instr = '0;
    w_err   = 1'b0;
    case (w_fmt)
      FMT_R: begin
        w_instr = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        w_instr = {imm[11:0], rs1, funct3, rd, opcode};
        w_err   = !w_hi11_ok;
      end
      FMT_S: begin
        w_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        w_err   = !w_hi11_ok;
      end
      FMT_B: begin
        w_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        w_err   = !w_hi12_ok || imm[0];
      end
      FMT_U: begin
        w_instr = {imm[31:12], rd, opcode};
        w_err   = |imm[11:0];
      end
      FMT_J: begin
        w_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_err   = !w_hi20_ok || imm[0];
      end
      FMT_SHIFT: begin
        w_instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        w_err   = |imm[31:5];
      end
      FMT_ILL: begin
        w_instr = '0;
        w_err   = 1'b1;
      end
      default: begin
        w_instr = '0;
        w_err   = 1'b1;
      end
    endcase
  end

  assign w_acc      = in_valid && r_in_ready;
  assign w_out_free = !r_out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_err   <= 1'b0;
      r_sk_valid  <= 1'b0;
      r_sk_instr  <= '0;
      r_sk_err    <= 1'b0;
      r_err_count <= '0;
    end else begin
      // in_ready is low whenever the skid holds a word, so skid refill and accept never coincide.
      if (w_out_free) begin
        if (r_sk_valid) begin
          r_out_valid <= 1'b1;
          r_out_instr <= r_sk_instr;
          r_out_err   <= r_sk_err;
          r_sk_valid  <= 1'b0;
        end else if (w_acc) begin
          r_out_valid <= 1'b1;
          r_out_instr <= w_instr;
          r_out_err   <= w_err;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_sk_valid <= 1'b1;
        r_sk_instr <= w_instr;
        r_sk_err   <= w_err;
      end

      r_in_ready <= !(!w_out_free && (r_sk_valid || w_acc));

      if (w_acc && w_err && !(&r_err_count)) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed vectors, backpressure, random soak, reset and saturation.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  int          total = 0;
  int          bad   = 0;
  logic [32:0] exp_q[$];
  int unsigned m_errs = 0;
  int unsigned accepted = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_instr;
  logic        stall_err;

  inst_encoder #(.ERR_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference: {err, instr} from the ISA field layout and signed-range rules.
  function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] op,
                                        input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] im);
    int          s;
    logic [31:0] w;
    logic        e;
    s = $signed(im);
    w = 32'd0;
    e = 1'b0;
    case (f)
      3'd0: w = {f7, s2, s1, f3, d, op};
      3'd1: begin w = {im[11:0], s1, f3, d, op}; e = (s < -2048) || (s > 2047); end
      3'd2: begin w = {im[11:5], s2, s1, f3, im[4:0], op}; e = (s < -2048) || (s > 2047); end
      3'd3: begin
        w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e = (s < -4096) || (s > 4095) || (s % 2 != 0);
      end
      3'd4: begin w = {im[31:12], d, op}; e = (im % 32'd4096) != 0; end
      3'd5: begin
        w = {im[20], im[10:1], im[11], im[19:12], d, op};
        e = (s < -(1 << 20)) || (s > (1 << 20) - 1) || (s % 2 != 0);
      end
      3'd6: begin w = {f7, im[4:0], s1, f3, d, op}; e = im > 32'd31; end
      default: begin w = 32'd0; e = 1'b1; end
    endcase
    return {e, w};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic set_f(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic rand_fields();
    fmt = 3'($urandom_range(0, 7));
    opcode = 7'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    funct3 = 3'($urandom); funct7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: imm = $urandom_range(0, 70);
      2: imm = 32'd0 - $urandom_range(0, 5000);
      default: begin
        imm = {($urandom_range(0, 1) != 0) ? 12'hFFF : 12'h000, 20'($urandom)};
        if ($urandom_range(0, 1) != 0) imm[11:0] = 12'h000;
      end
    endcase
  endtask

  // Called at a negedge with inputs already driven; scores both handshakes, then advances one cycle.
  task automatic step();
    logic [32:0] e;
    if (stall_prev) begin
      chk("stall_instr", out_instr, stall_instr);
      chk("stall_err", 32'(out_err), 32'(stall_err));
    end
    stall_prev  = out_valid && !out_ready;
    stall_instr = out_instr;
    stall_err   = out_err;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_instr", out_instr, e[31:0]);
        chk("out_err", 32'(out_err), 32'(e[32]));
      end
    end
    if (in_valid && in_ready) begin
      e = model(fmt, opcode, rd, rs1, rs2, funct3, funct7, imm);
      exp_q.push_back(e);
      if (e[32] && m_errs != 32'hFFFF) m_errs++;
      accepted++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input string tag, input logic [31:0] exp_instr, input logic exp_err);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instr, exp_instr);
    chk({tag, "_err"}, 32'(out_err), 32'(exp_err));
    step();
  endtask

  initial begin
    int unsigned start;
    int unsigned cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_f(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    set_f(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    send("i_neg1", 32'hFFF0_0093, 1'b0);
    set_f(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send("i_2048", 32'h8000_0093, 1'b1);
    set_f(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hFFFF_FFFF);
    send("r_sub", 32'h4031_00B3, 1'b0);
    set_f(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    send("s_sw", 32'h0020_A423, 1'b0);
    set_f(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    send("b_m4", 32'hFE20_8EE3, 1'b0);
    set_f(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096);
    send("b_4096", 32'h8020_8063, 1'b1);
    chk("err_count_b", 32'(err_count), 32'd2);
    set_f(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
    send("b_odd", 32'h0020_8163, 1'b1);
    set_f(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    send("j_2048", 32'h0010_00EF, 1'b0);
    set_f(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    send("u_ok", 32'h1234_52B7, 1'b0);
    set_f(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    send("u_low", 32'h1234_52B7, 1'b1);
    set_f(3'd6, 7'h13, 5'd2, 5'd2, 5'd0, 3'd5, 7'h20, 32'd3);
    send("sh_3", 32'h4031_5113, 1'b0);
    set_f(3'd6, 7'h13, 5'd2, 5'd2, 5'd0, 3'd5, 7'h20, 32'd32);
    send("sh_32", 32'h4001_5113, 1'b1);
    set_f(3'd7, 7'h33, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'd0);
    send("fmt7", 32'h0000_0000, 1'b1);
    chk("err_count_dir", 32'(err_count), 32'd6);

    // Backpressure: three offered with out_ready low, only two fit.
    out_ready = 1'b0; in_valid = 1'b1;
    start = accepted;
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      chk("bp_in_ready", 32'(in_ready), (i < 2) ? 32'd1 : 32'd0);
      step();
    end
    chk("bp_accepted", accepted - start, 32'd2);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    step();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Back-to-back with out_ready high: one word per cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      step();
      chk("tput_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    step();

    start = accepted;
    cyc = 0;
    while ((accepted - start) < 10000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 7) != 0);
      rand_fields();
      step();
      cyc++;
    end
    chk("soak_accepted", accepted - start, 32'd10000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("soak_drained", 32'(exp_q.size()), 32'd0);
    chk("soak_err_count", 32'(err_count), m_errs);

    // Reset with two words buffered.
    out_ready = 1'b0; in_valid = 1'b1;
    rand_fields(); step();
    rand_fields(); step();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    m_errs = 0;
    stall_prev = 1'b0;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_no_out", 32'(out_valid), 32'd0);
    end

    // Saturation: 2^16+5 errored requests.
    set_f(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    start = 0; cyc = 0;
    while (start < 65541 && cyc < 70000) begin
      if (in_ready) start++;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("sat_accepted", start, 32'd65541);
    @(posedge clk); @(negedge clk);
    chk("sat_err_count", 32'(err_count), 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Streaming RISC-V RV32I instruction encoder. It takes decoded fields (format, opcode, registers, functs, full-width immediate) and packs them into a 32-bit instruction word.
- It is the inverse of the core's immediate generator. It is used by the instruction-memory loader and the self-test sequencer to build programs in hardware.
- Immediates are range- and alignment-checked.
- Valid/ready on both sides; registered output with a skid buffer, so in_ready has no combinational path from out_ready.

Parameters:
ERR_CNT_W, 16, width of saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept request (registered)
fmt  input  3  0=R,1=I,2=S,3=B,4=U,5=J,6=SHIFT(I-type shamt),7=illegal
opcode  input  7  placed in instr[6:0]
rd  input  5  destination reg
rs1  input  5  source reg 1
rs2  input  5  source reg 2
funct3  input  3  function field
funct7  input  7  R and SHIFT only
imm  input  32  full signed immediate value (byte offset for B/J; final value for U)
out_valid  output  1  encoded word valid
out_ready  input  1  downstream accepts
out_instr  output  32  encoded instruction
out_err  output  1  immediate out of range/misaligned or illegal fmt, aligned with out_instr
err_count  output  ERR_CNT_W  saturating count of accepted requests with error

Behaviour:
- Reset (async, rst=1): out_valid=0, out_instr=0, out_err=0, err_count=0, skid empty, in_ready=0 while rst high. in_ready=1 in first cycle after release.
- Transfer on either side = valid&&ready on a rising clk edge.
- Packing:
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I: {imm[11:0],rs1,funct3,rd,opcode}
  - SHIFT: {funct7,imm[4:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U: {imm[31:12],rd,opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
  - fmt=7: out_instr=0.
- Error rules (out_err=1); the word is still encoded from truncated bits except for fmt 7:
  - I/S: imm[31:11] not all equal.
  - SHIFT: imm[31:5]!=0.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0]!=0.
  - R: never.
  - fmt 7: always.
- Latency: an accepted input appears on out_* at the next edge when the output register is empty or draining. Minimum 1 cycle.
- Throughput: 1 word/cycle while out_ready=1.
- Buffering: output register plus one skid entry.
  - out_ready=0 while out_valid=1: the next accepted request goes to skid. in_ready drops next cycle.
  - When the output drains, skid moves to the output register on the same edge. in_ready rises next cycle.
  - Ordering is strictly FIFO.
  - Never drop or duplicate a request.
- Stall stability: out_instr/out_err are stable while out_valid&&!out_ready.
- err_count increments at input acceptance of an errored request and saturates at all-ones (no wrap).
- Simultaneous input accept and output drain with skid empty: output register loads the new word and out_valid stays 1.
- Reset mid-stream: all buffered words are discarded and nothing is emitted after release.
- Fields are ignored by the format that doesn't use them (e.g. rs2 for I) and need no error check.

Test Plan:
- Reset then I: opcode=0x13,rd=1,rs1=0,funct3=0,imm=-1 -> out_instr=0xFFF00093, out_err=0, 1-cycle latency.
- B fmt: opcode=0x63,rs1=1,rs2=2,funct3=0,imm=-4 -> 0xFE208EE3. Same with imm=4096 -> out_err=1, err_count=1. imm=3 -> out_err=1.
- J imm=2048,rd=1,opcode=0x6F -> 0x001000EF. U imm=0x12345000,rd=5,opcode=0x37 -> 0x123452B7. U imm=0x12345001 -> out_err=1.
- SHIFT funct7=0x20,imm=3,rs1=2,funct3=5,rd=2,opcode=0x13 -> 0x40315113. imm=32 -> out_err=1. fmt=7 -> out_instr=0, out_err=1.
- Backpressure: hold out_ready=0 and push 3 requests -> 2 accepted, in_ready=0. Release -> words out in order, one per cycle, no loss. Random valid/ready soak of 10k words against a reference model.
- Assert rst with 2 words buffered -> out_valid=0 immediately, err_count=0. No stale output after release. Feed 2^16+5 errored requests -> err_count=0xFFFF.
